fifo_rr_write_arbiter: RTL
==========================

Name: fifo_rr_write_arbiter

Overview:
- Shares the single write port of one FIFO controller between N_REQ producer streams, e.g. multiple MAC lanes pushing results into one output buffer.
- Round-robin arbitration with burst locking.
- Drives the FIFO's write_enable and write data, and respects the FIFO's full flag so that no write is ever presented while full.
- Sits between the producer lanes and the FIFO controller plus its RAM.

Parameters:
- N_REQ, 4: number of requesters, ≥1.
- DATA_W, 16: width of each data word.
- BURST_LEN, 4: maximum beats one owner may write per grant, ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester word valid.
- req_data  in  N_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  per-requester accept.
- fifo_full  in  1  full flag from the FIFO controller.
- fifo_write_enable  out  1  write strobe to the FIFO controller.
- fifo_write_data  out  DATA_W  word to the FIFO RAM.
- grant_id  out  max(1,$clog2(N_REQ))  current owner index.
- busy  out  1  high while in LOCKED.

Behaviour:
- State machine: IDLE, LOCKED. Registered state: state, owner, rr_ptr, beat_cnt (width $clog2(BURST_LEN+1)).
- Reset (async): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - req_ready=0, fifo_write_enable=0, busy=0, grant_id=0 and fifo_write_data=0 take effect immediately, not at the next edge.
- IDLE:
  - req_ready all 0.
  - If any req_valid is set, choose the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Next edge: owner=i, beat_cnt=0, state=LOCKED.
  - If no valid, stay in IDLE.
  - The grant is always preceded by one IDLE cycle, so the first possible transfer is 1 cycle after valid is seen.
- LOCKED outputs (all combinational from registered state and inputs):
  - req_ready[owner] = ~fifo_full; all other ready bits are 0.
  - transfer = req_valid[owner] & req_ready[owner].
  - fifo_write_enable = transfer.
  - fifo_write_data = req_data slice of owner when transfer, else 0.
  - grant_id = owner; busy = 1.
- LOCKED sequencing:
  - On transfer: beat_cnt += 1.
  - Release when the transfer is beat number BURST_LEN, i.e. beat_cnt == BURST_LEN-1 at the transfer.
  - Release when req_valid[owner]=0 in any LOCKED cycle. This is the owner's end of stream. The check is independent of fifo_full.
  - On release, next edge: state=IDLE, rr_ptr=(owner+1) mod N_REQ, beat_cnt=0.
- fifo_full high in LOCKED:
  - No write occurs and beat_cnt freezes.
  - Ownership is held indefinitely; there is no timeout.
  - If the owner drops valid while full, release applies.
- Simultaneous requests: strict round-robin from rr_ptr. A lone requester regains the grant after one IDLE bubble.
- N_REQ=1: rr_ptr stays 0; grant_id is 1 bit and is constant 0.
- req_valid from non-owners is ignored in LOCKED. Producers must hold valid and data stable until ready; this is a protocol requirement and is not checked.
- A mid-burst reset abandons the burst with no write on the reset cycle. Any word already accepted is in the FIFO.

Optional Feature:
- Macro: FIFO_ARB_BURST_EN.
- Defined: burst locking as described, up to BURST_LEN beats per grant.
- Undefined: BURST_LEN is ignored and treated as 1. Every grant releases after a single transfer, giving word-interleaved round-robin.
- Ports and IDLE/LOCKED structure are identical in both builds.

Test Plan:
- Reset then idle (all valid=0 for 10 cycles) -> req_ready=0000, fifo_write_enable=0, busy=0 throughout.
- Requesters 0 and 2 continuously valid, fifo_full=0, BURST_LEN=4, burst enabled. Expected:
  - Writes are 4 words from req0, a 1-cycle IDLE gap, 4 words from req2, a gap, then req0 again.
  - grant_id sequence is 0, 2, 0.
  - Same stimulus with FIFO_ARB_BURST_EN undefined -> writes alternate 0, 2, 0, 2, one word per grant.
- Owner 1 in LOCKED, fifo_full forced high for 5 cycles after its 2nd beat. Expected:
  - req_ready[1]=0 and no writes for those 5 cycles; beat_cnt holds at 2.
  - After full drops, 2 more beats complete, then release.
- Owner 3 drops valid after 1 beat. Expected: next cycle IDLE, rr_ptr=0, req0 (valid) wins the next grant.
- Reset asserted mid-burst while asynchronous to clk. Expected:
  - Outputs go to 0 within the same cycle with no write.
  - After deassert, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/fifo_rr_write_arbiter.sv
// fifo_rr_write_arbiter
//   Shares one FIFO write port between N_REQ producer streams. Arbitration is
//   round-robin from rr_ptr. The chosen owner keeps the port for up to
//   BURST_LEN beats, or until it drops valid. A write is never presented
//   while fifo_full is high. Each grant is preceded by exactly one IDLE cycle.
//
//   Build option: define FIFO_ARB_BURST_EN to enable burst locking. Without
//   it, every grant releases after one transfer, which gives word-interleaved
//   round-robin.
//
//   Ports
//     clk, reset          clock; asynchronous active-high reset
//     req_valid/ready     per-requester handshake [N_REQ]
//     req_data            packed words, requester i at [i*DATA_W +: DATA_W]
//     fifo_full           FIFO full flag
//     fifo_write_enable   write strobe (high only on a real transfer)
//     fifo_write_data     written word; zero when there is no transfer
//     grant_id            current owner index
//     busy                high while a grant is held (LOCKED)

// Per-lane gating: ready, transfer and the masked data contribution.
module fifo_rr_write_arbiter_lane #(
  parameter int DATA_W = 16
) (
  input  logic              sel,
  input  logic              fifo_full,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              transfer,
  output logic [DATA_W-1:0] wdata
);
  assign ready    = sel & ~fifo_full;
  assign transfer = ready & valid;
  // Masked to zero so the top can OR all lanes together.
  assign wdata    = transfer ? data : '0;
endmodule

module fifo_rr_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_write_enable,
  output logic [DATA_W-1:0]       fifo_write_data,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
`ifdef FIFO_ARB_BURST_EN
  localparam int EFF_BURST = BURST_LEN;
`else
  localparam int EFF_BURST = 1;
`endif
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(EFF_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   owner, owner_nxt, rr_ptr, rr_nxt, pick_id;
  logic [CNT_W-1:0]  beat_cnt, beat_nxt;
  logic              pick_found, transfer, owner_valid, release_grant;
  int                idx;

  logic [N_REQ-1:0]             lane_sel, lane_ready, lane_xfer;
  logic [N_REQ-1:0][DATA_W-1:0] lane_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane_sel[gi] = (state == LOCKED) && (owner == ID_W'(gi));
      fifo_rr_write_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
        .sel      (lane_sel[gi]),
        .fifo_full(fifo_full),
        .valid    (req_valid[gi]),
        .data     (req_data[gi*DATA_W +: DATA_W]),
        .ready    (lane_ready[gi]),
        .transfer (lane_xfer[gi]),
        .wdata    (lane_wdata[gi])
      );
    end
  endgenerate

  assign transfer    = |lane_xfer;
  // Only one lane is selected, so this is req_valid[owner] while LOCKED.
  assign owner_valid = |(req_valid & lane_sel);
  // End-of-stream release does not depend on fifo_full.
  assign release_grant = ~owner_valid | (transfer & (beat_cnt == LAST_BEAT));

  // Round-robin scan starting at rr_ptr; the first valid requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = LOCKED;
          owner_nxt = pick_id;
          beat_nxt  = '0;
        end
      end
      LOCKED: begin
        if (release_grant) begin
          state_nxt = IDLE;
          rr_nxt    = (owner == LAST_ID) ? '0 : owner + 1'b1;
          beat_nxt  = '0;
        end else if (transfer) begin
          beat_nxt  = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: combinational from registered state, so reset clears them at once.
  always_comb begin
    req_ready         = lane_ready;
    fifo_write_enable = transfer;
    fifo_write_data   = '0;
    for (int i = 0; i < N_REQ; i++)
      fifo_write_data = fifo_write_data | lane_wdata[i];
    grant_id          = owner;
    busy              = (state == LOCKED);
  end
endmodule
